// File: rtl/ca_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ca_pipe_pkg
// Description : Shared types and constants for CA-LAB pipeline stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
package ca_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_LANES = 2;
    localparam int unsigned OCC_W     = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_t;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t st);
        case (st)
            ST_ONE:  occ_of = OCC_W'(1);
            ST_TWO:  occ_of = OCC_W'(2);
            default: occ_of = OCC_W'(0);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Multi-lane pipeline register with valid/ready, 2-entry skid
//               buffer, flush and occupancy reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
    import ca_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH   = DEF_WIDTH,
    parameter int unsigned       LANES   = DEF_LANES,
    parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]       occupancy
);

    localparam int unsigned DW = LANES * WIDTH;

    skid_state_t   state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] clr_word;
    logic          acc;
    logic          take;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign clr_word[k*WIDTH +: WIDTH] = CLR_VAL;
        end
    endgenerate

    // Handshake flags decode from the state flops only, so in_ready never
    // depends combinationally on out_ready.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);
    assign occupancy = occ_of(state_q);
    assign out_data  = main_q;

    assign acc  = in_valid & in_ready;
    assign take = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= ST_EMPTY;
            main_q  <= clr_word;
            skid_q  <= clr_word;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_q <= ST_ONE;
                        main_q  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_q <= in_data;
                    end else if (acc) begin
                        state_q <= ST_TWO;
                        skid_q  <= in_data;
                    end else if (take) begin
                        state_q <= ST_EMPTY;
                        main_q  <= clr_word;
                    end
                end
                ST_TWO: begin
                    // Skid always holds the younger word; promote it on drain.
                    if (take) begin
                        state_q <= ST_ONE;
                        main_q  <= skid_q;
                        skid_q  <= clr_word;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    main_q  <= clr_word;
                    skid_q  <= clr_word;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Directed plus random bench for pipe_skid_reg, queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int W  = 32;
    localparam int L  = 2;
    localparam int DW = W * L;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic          in_ready1, out_valid1;
    logic [DW-1:0] out_data1;
    logic [1:0]    occupancy1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .LANES(L), .CLR_VAL(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_skid_reg #(.WIDTH(W), .LANES(L), .CLR_VAL(32'hFFFF_FFFF)) dut_ones (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occupancy1)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        check({tag, ".out_valid"}, DW'(out_valid), DW'(sz > 0));
        check({tag, ".in_ready"},  DW'(in_ready),  DW'(sz < 2));
        check({tag, ".occupancy"}, DW'(occupancy), DW'(sz));
        check({tag, ".out_data"},  out_data, (sz > 0) ? mq[0] : '0);
    endtask

    task automatic cyc(input string tag, input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
        logic          acc_m, take_m;
        logic [DW-1:0] dropped;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        acc_m  = iv && (mq.size() < 2);
        take_m = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (r || f) begin
            mq.delete();
        end else begin
            if (take_m) dropped = mq.pop_front();
            if (acc_m)  mq.push_back(d);
        end
        check_model(tag);
    endtask

    initial begin
        logic r, f, iv, ordy;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // 1. Reset
        cyc("rst0", 1, 0, 0, '0, 0);
        cyc("rst1", 1, 0, 0, '0, 0);
        check("rst.ones_data", out_data1, ONES);
        check("rst.ones_valid", DW'(out_valid1), '0);

        // 2. Streaming
        cyc("st1", 0, 0, 1, {32'h1, 32'hA}, 1);
        cyc("st2", 0, 0, 1, {32'h2, 32'hB}, 1);
        cyc("st3", 0, 0, 1, {32'h3, 32'hC}, 1);
        check("st3.data_lit", out_data, {32'h3, 32'hC});
        cyc("st4", 0, 0, 0, '0, 1);

        // 3. Backpressure
        cyc("bp1", 0, 0, 1, {32'h11, 32'h22}, 0);
        cyc("bp2", 0, 0, 1, {32'h33, 32'h44}, 0);
        cyc("bp3", 0, 0, 1, {32'h55, 32'h66}, 0);
        check("bp3.data_lit", out_data, {32'h11, 32'h22});
        check("bp3.occ_lit", DW'(occupancy), DW'(2));
        cyc("bp4", 0, 0, 0, '0, 1);
        check("bp4.data_lit", out_data, {32'h33, 32'h44});
        cyc("bp5", 0, 0, 0, '0, 1);
        cyc("bp6", 0, 0, 0, '0, 1);

        // 4. Flush while full
        cyc("fl1", 0, 0, 1, 64'h77, 0);
        cyc("fl2", 0, 0, 1, 64'h88, 0);
        cyc("fl3", 0, 1, 1, 64'hDEAD, 0);
        check("fl3.data_lit", out_data, '0);
        cyc("fl4", 0, 0, 0, '0, 1);

        // 5. Accept and take together in ONE
        cyc("at1", 0, 0, 1, 64'h5, 0);
        cyc("at2", 0, 0, 1, 64'h6, 1);
        check("at2.data_lit", out_data, 64'h6);

        // 6. Reset over flush
        cyc("rf1", 1, 1, 1, 64'h9, 0);
        check("rf1.ones_data", out_data1, ONES);
        check("rf1.ones_occ", DW'(occupancy1), '0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 99) == 0);
            f    = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc("rnd", r, f, iv, {$urandom, $urandom}, ordy);
            if (r) check("rnd.ones_data", out_data1, ONES);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
